uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver that sits directly upstream of the program loader: turns the raw `rx` pin into a stream of bytes.
- Each byte is presented to the loader with a valid/ack handshake; the loader then turns the bytes into 21-bit address and data writes on the external bus.
- Runs on the undivided board clock, never the divided CPU clock.
- Detects framing errors, false start bits and overruns.

Parameters:
- CLKS_PER_BIT, 104, board clock cycles per UART bit. Must be >= 4. Default gives 115200 baud at 12 MHz.

Ports:
- clk  input  1  board clock; all logic is on its rising edge.
- n_reset  input  1  synchronous, active-low reset.
- rx  input  1  asynchronous serial line; idle level is high.
- data  output  8  last good received byte, LSB = first data bit.
- valid  output  1  `data` holds an unconsumed byte.
- ack  input  1  consumer has taken `data`; clears `valid`.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- overrun  output  1  one-cycle pulse when a byte lands while the previous one is unconsumed.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (n_reset=0 at a clk edge):
  - Outputs: data=0, valid=0, frame_err=0, overrun=0, busy=0.
  - Synchronizer flops = 1; state=IDLE; bit counter and bit index = 0.
  - Reset mid-frame abandons the frame; no pulse or valid is produced for it.
- Synchronizer:
  - `rx` passes through 2 flops, giving `rxs`, then one more delay flop, giving `rxp`.
  - All decisions use `rxs`. Pin-to-`rxs` latency is 2 cycles.
- Let H = CLKS_PER_BIT/2, integer division.
- State IDLE:
  - Falling edge (`rxp`=1, `rxs`=0) → START, cnt=0.
- State START:
  - cnt increments every cycle.
  - At cnt=H-1, sample `rxs`:
    - 1 → false start, go to IDLE, no pulse.
    - 0 → DATA, cnt=0, idx=0.
- State DATA:
  - cnt increments.
  - At cnt=CLKS_PER_BIT-1: shift `rxs` into a shift register from the MSB side (LSB-first line order), cnt=0, idx++.
  - After the sample with idx=7 → STOP.
- State STOP:
  - At cnt=CLKS_PER_BIT-1, sample `rxs`:
    - 1 → go to IDLE. On the next cycle: data=shift register, valid=1.
    - 0 → go to BREAK. On the next cycle: frame_err=1 for 1 cycle. data and valid are untouched.
- State BREAK:
  - Stay until `rxs`=1, then go to IDLE. A held-low line therefore yields exactly one frame_err.
  - A new frame can start right after the STOP sample (back-to-back frames, no extra idle).
- Handshake:
  - `valid` stays high until a cycle with ack=1; it drops on the following edge.
  - ack while valid=0 is ignored.
- Byte completes while valid=1 (new data registered on the same edge):
  - ack=0 that cycle → data is overwritten, valid stays 1, overrun pulses 1 cycle.
  - ack=1 that same cycle → data is overwritten, valid stays 1, no overrun.
- Timing:
  - Falling edge seen on `rxs` at cycle T.
  - Data bit i is sampled at T+H+(i+1)·CLKS_PER_BIT.
  - Stop bit is sampled at T+H+9·CLKS_PER_BIT.
  - valid (or frame_err) is high from the next cycle onward.
- All counters are wide enough for CLKS_PER_BIT-1 and must never wrap inside a bit.

Test Plan:
- Clean byte: CLKS_PER_BIT=16, send 0xA5 as 8N1 at exactly 16 cycles/bit → valid rises exactly H+9·16+1 = 153 cycles after the falling edge reaches `rxs`; data=0xA5; frame_err=0; overrun=0.
- False start: CLKS_PER_BIT=16, 5-cycle low glitch on rx → busy high for 8 cycles then 0, no valid, no frame_err; then send 0x3C → data=0x3C.
- Framing error: send 0x55 with stop bit low, then hold rx low 100 cycles → exactly one frame_err pulse, valid=0, data unchanged, busy stays high until rx goes high.
- Overrun and ack: send 0x11 and 0x22 back-to-back with no ack → valid=1, data=0x22, one overrun pulse. Repeat with ack asserted on the cycle 0x22 lands → no overrun, data=0x22, valid=1. Then ack → valid=0 on the next cycle.
- Reset mid-frame: pull n_reset low for 1 cycle during data bit 4 of 0xFF, then idle → all outputs 0, no valid; next frame 0x81 received correctly.
- Baud tolerance: send 0x0F at 16·1.04 and 16·0.96 cycles/bit → data=0x0F, no frame_err in both cases.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver feeding the program loader from the raw rx pin.
// Oversamples on the board clock and hands bytes over with valid/ack.
module uart_rx #(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ack,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BRK
   } state_t;

   state_t           state_q, state_d;
   logic             meta_q, meta_d;
   logic             rxs_q, rxs_d;
   logic             rxp_q, rxp_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;
   logic             ovr_q, ovr_d;
   logic             busy_q, busy_d;
   logic             bit_end;

   always_comb begin
      meta_d  = rx;
      rxs_d   = meta_q;
      rxp_d   = rxs_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = valid_q & ~ack;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
      bit_end = (cnt_q == BIT_M1);

      unique case (state_q)
         IDLE: begin
            if (rxp_q && !rxs_q) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d = '0;
               idx_d = '0;
               state_d = rxs_q ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d = {rxs_q, shift_q[7:1]};
               cnt_d   = '0;
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  state_d = STOP;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               if (rxs_q) begin
                  state_d = IDLE;
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  // an ack landing on the same edge frees the slot in time
                  ovr_d   = valid_q & ~ack;
               end else begin
                  state_d = BRK;
                  ferr_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         BRK: begin
            if (rxs_q) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state_q <= IDLE;
         meta_q  <= 1'b1;
         rxs_q   <= 1'b1;
         rxp_q   <= 1'b1;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         meta_q  <= meta_d;
         rxs_q   <= rxs_d;
         rxp_q   <= rxp_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
         busy_q  <= busy_d;
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against an event-schedule model of uart_rx.
// Expected bytes/pulses are placed at the stop-sample edge of each frame.
module tb_uart_rx;

   localparam int CPB = 16;
   localparam int H   = CPB / 2;
   localparam int LAT = 2 + H + 9 * CPB;

   logic       clk = 1'b0;
   logic       n_reset = 1'b0;
   logic       rx = 1'b1;
   logic       ack = 1'b0;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk),
      .n_reset(n_reset),
      .rx(rx),
      .data(data),
      .valid(valid),
      .ack(ack),
      .frame_err(frame_err),
      .overrun(overrun),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         at;
      bit         good;
      logic [7:0] b;
   } ev_t;

   typedef struct {
      int t0;
      int t1;
   } iv_t;

   ev_t        evq[$];
   iv_t        ivq[$];
   int         cyc = 0;
   bit         armed = 1'b0;
   bit         m_valid = 1'b0;
   bit         m_fe = 1'b0;
   bit         m_ov = 1'b0;
   bit         m_busy = 1'b0;
   logic [7:0] m_data = 8'h00;
   int         n_vec = 0;
   int         n_bad = 0;
   int         fe_cnt = 0;
   int         ov_cnt = 0;
   int         rise_cyc = -1;
   bit         pv = 1'b0;

   always @(posedge clk) begin : model
      bit old_v;
      cyc = cyc + 1;
      m_fe = 1'b0;
      m_ov = 1'b0;
      if (!n_reset) begin
         armed = 1'b1;
         m_valid = 1'b0;
         m_data = 8'h00;
         evq.delete();
         foreach (ivq[i]) if (ivq[i].t1 > cyc) ivq[i].t1 = cyc;
      end else begin
         old_v = m_valid;
         if (ack) m_valid = 1'b0;
         foreach (evq[i]) begin
            if (evq[i].at == cyc) begin
               if (evq[i].good) begin
                  m_data = evq[i].b;
                  m_valid = 1'b1;
                  m_ov = old_v && !ack;
               end else begin
                  m_fe = 1'b1;
               end
            end
         end
      end
      m_busy = 1'b0;
      foreach (ivq[i]) if (ivq[i].t0 <= cyc && cyc < ivq[i].t1) m_busy = 1'b1;
   end

   always @(negedge clk) begin
      if (armed) begin
         n_vec = n_vec + 1;
         if (data !== m_data || valid !== m_valid || frame_err !== m_fe ||
             overrun !== m_ov || busy !== m_busy) begin
            n_bad = n_bad + 1;
            if (n_bad <= 20)
               $display("FAIL cycle %0d: got d=%h v=%b fe=%b ov=%b busy=%b, want d=%h v=%b fe=%b ov=%b busy=%b",
                        cyc, data, valid, frame_err, overrun, busy,
                        m_data, m_valid, m_fe, m_ov, m_busy);
         end
      end
      if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
      if (overrun === 1'b1) ov_cnt = ov_cnt + 1;
      if (valid === 1'b1 && !pv) rise_cyc = cyc;
      pv = (valid === 1'b1);
   end

   task automatic chk(input string nm, input int got, input int want);
      n_vec = n_vec + 1;
      if (got != want) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %0d want %0d", nm, got, want);
      end
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
   endtask

   // Drives one frame from a negedge; bw100 is the bit width in 1/100 cycles.
   task automatic send(input logic [7:0] b, input bit stop, input int bw100,
                       input int rst_off, input int ack_off,
                       output int f, output int iv_idx);
      logic [9:0] line;
      int total;
      int j;
      line = {stop, b, 1'b0};
      total = (10 * bw100) / 100;
      f = cyc + 1;
      if (rst_off < 0) evq.push_back('{at: f + LAT, good: stop, b: b});
      ivq.push_back('{t0: f + 2, t1: stop ? f + LAT : 32'h7fffffff});
      iv_idx = ivq.size() - 1;
      for (int k = 0; k < total; k++) begin
         j = 0;
         while (j < 9 && ((j + 1) * bw100) / 100 <= k) j++;
         rx = line[j];
         n_reset = !(k == rst_off);
         if (ack_off >= 0) ack = (k == ack_off);
         @(negedge clk);
      end
      n_reset = 1'b1;
      ack = 1'b0;
   endtask

   initial begin
      int f, f2, iv, bc, fe0, ov0;
      n_reset = 1'b0;
      repeat (4) @(negedge clk);
      n_reset = 1'b1;
      chk("reset_outs", int'({data, valid, frame_err, overrun, busy}), 0);
      idle(10);

      send(8'hA5, 1'b1, 1600, -1, -1, f, iv);
      idle(10);
      chk("lat_a5", rise_cyc - (f + 1), 153);
      chk("data_a5", int'(data), 8'hA5);
      chk("fe_a5", fe_cnt, 0);
      pulse_ack();
      idle(5);

      f = cyc + 1;
      ivq.push_back('{t0: f + 2, t1: f + 2 + H});
      bc = 0;
      for (int k = 0; k < 30; k++) begin
         rx = (k < 5) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (busy === 1'b1) bc++;
      end
      chk("glitch_busy", bc, 8);
      chk("glitch_valid", int'(valid), 0);
      send(8'h3C, 1'b1, 1600, -1, -1, f, iv);
      idle(10);
      chk("data_3c", int'(data), 8'h3C);
      pulse_ack();
      idle(5);

      fe0 = fe_cnt;
      send(8'h55, 1'b0, 1600, -1, -1, f, iv);
      repeat (100) @(negedge clk);
      chk("brk_busy", int'(busy), 1);
      rx = 1'b1;
      ivq[iv].t1 = cyc + 1 + 2;
      idle(20);
      chk("fe_once", fe_cnt - fe0, 1);
      chk("fe_valid", int'(valid), 0);
      chk("fe_data", int'(data), 8'h3C);

      ov0 = ov_cnt;
      send(8'h11, 1'b1, 1600, -1, -1, f, iv);
      send(8'h22, 1'b1, 1600, -1, -1, f2, iv);
      idle(10);
      chk("ov_once", ov_cnt - ov0, 1);
      chk("ov_data", int'(data), 8'h22);
      chk("ov_valid", int'(valid), 1);
      pulse_ack();
      idle(5);
      ov0 = ov_cnt;
      send(8'h11, 1'b1, 1600, -1, -1, f, iv);
      send(8'h22, 1'b1, 1600, -1, LAT, f2, iv);
      idle(10);
      chk("ack_ov", ov_cnt - ov0, 0);
      chk("ack_data", int'(data), 8'h22);
      chk("ack_valid", int'(valid), 1);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk("ack_drop", int'(valid), 0);
      idle(5);

      send(8'hFF, 1'b1, 1600, 5 * CPB + H, -1, f, iv);
      idle(30);
      chk("rst_outs", int'({data, valid, frame_err, overrun, busy}), 0);
      send(8'h81, 1'b1, 1600, -1, -1, f, iv);
      idle(10);
      chk("data_81", int'(data), 8'h81);
      pulse_ack();
      idle(5);

      fe0 = fe_cnt;
      send(8'h0F, 1'b1, 1664, -1, -1, f, iv);
      idle(20);
      chk("slow_data", int'(data), 8'h0F);
      pulse_ack();
      idle(5);
      send(8'h0F, 1'b1, 1536, -1, -1, f, iv);
      idle(20);
      chk("fast_data", int'(data), 8'h0F);
      chk("tol_fe", fe_cnt - fe0, 0);
      idle(10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
